// File: rtl/ps2_tx_if.sv
// Host-side command handshake of the PS/2 transmitter: request, byte, and
// busy/done/err status back to the controller.
interface ps2_tx_if;
    logic       start;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output start, output din, input busy, input done, input err);
    modport slave  (input start, input din, output busy, output done, output err);
endinterface

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift the frame out
// on device clock falls, check the device acknowledge and report done/err.
module ps2_tx #(
    parameter int INHIBIT_CYC = 3000,
    parameter int REQ_CYC     = 25,
    parameter int TIMEOUT_CYC = 375000
) (
    input  logic    clk,
    input  logic    rst,
    ps2_tx_if.slave host,
    output logic    ps2c_low,
    output logic    ps2d_low,
    input  logic    PS2C,
    input  logic    PS2D
);
    localparam int MAX_AB  = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       n_q, n_d;
    logic [7:0]       sh_q, sh_d;
    logic             par_q, par_d;
    logic             cl_q, cl_d;
    logic             dl_q, dl_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ackbad_q, ackbad_d;
    logic             c_meta_q, c_sync_q, c_prev_q;
    logic             d_meta_q, d_sync_q;
    logic             fall;
    logic             to_hit;

    // Line synchronizers reset to the released (high) level so reset never fakes a fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_meta_q <= 1'b1;
            c_sync_q <= 1'b1;
            c_prev_q <= 1'b1;
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
        end else begin
            c_meta_q <= PS2C;
            c_sync_q <= c_meta_q;
            c_prev_q <= c_sync_q;
            d_meta_q <= PS2D;
            d_sync_q <= d_meta_q;
        end
    end

    assign fall   = c_prev_q & ~c_sync_q;
    assign to_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            cl_q     <= 1'b0;
            dl_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ackbad_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            cl_q     <= cl_d;
            dl_q     <= dl_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ackbad_q <= ackbad_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q  <= sh_d;
        par_q <= par_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        sh_d     = sh_q;
        par_d    = par_q;
        cl_d     = cl_q;
        dl_d     = dl_q;
        done_d   = 1'b0;
        err_d    = err_q;
        ackbad_d = ackbad_q;
        case (state_q)
            S_IDLE: begin
                cl_d = 1'b0;
                dl_d = 1'b0;
                if (host.start) begin
                    sh_d    = host.din;
                    par_d   = ~^host.din;
                    cnt_d   = '0;
                    n_d     = '0;
                    cl_d    = 1'b1;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    dl_d    = 1'b1;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                if (cnt_q == REQ_LAST) begin
                    cnt_d   = '0;
                    cl_d    = 1'b0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                // A fall outranks the timeout terminal count.
                if (fall) begin
                    cnt_d = '0;
                    n_d   = n_q + 4'd1;
                    if (n_q <= 4'd7) begin
                        dl_d = ~sh_q[0];
                        sh_d = {1'b0, sh_q[7:1]};
                    end else if (n_q == 4'd8) begin
                        dl_d = ~par_q;
                    end else if (n_q == 4'd9) begin
                        dl_d = 1'b0;
                    end else begin
                        dl_d     = 1'b0;
                        ackbad_d = d_sync_q;
                        state_d  = S_ACK;
                    end
                end else if (to_hit) begin
                    cl_d    = 1'b0;
                    dl_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                if (c_sync_q && d_sync_q) begin
                    done_d  = 1'b1;
                    err_d   = ackbad_q;
                    state_d = S_IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (to_hit) begin
                    cl_d    = 1'b0;
                    dl_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cl_d    = 1'b0;
                dl_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign host.busy = (state_q != S_IDLE);
    assign host.done = done_q;
    assign host.err  = err_q;
    assign ps2c_low  = cl_q;
    assign ps2d_low  = dl_q;
endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: randomized sends against a PS/2 device model, with a
// scoreboard of expected frames and completion status.
module tb_ps2_tx;
    localparam int INH = 40;
    localparam int RQ  = 5;
    localparam int TO  = 400;

    typedef struct packed {
        logic [10:0] frame;
        logic        chk_frame;
        logic        timeout;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ps2c_low, ps2d_low, PS2C, PS2D;
    logic dev_cl = 1'b0;
    logic dev_dl = 1'b0;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   dev_mode = 0;
    int   dev_half = 20;
    int   dev_nrise = 0;

    exp_t        exp_q[$];
    logic [10:0] rx_q[$];

    ps2_tx_if hif();

    ps2_tx #(.INHIBIT_CYC(INH), .REQ_CYC(RQ), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .host     (hif),
        .ps2c_low (ps2c_low),
        .ps2d_low (ps2d_low),
        .PS2C     (PS2C),
        .PS2D     (PS2D)
    );

    // Open-collector lines: either side pulling low wins.
    assign PS2C = (ps2c_low || dev_cl) ? 1'b0 : 1'b1;
    assign PS2D = (ps2d_low || dev_dl) ? 1'b0 : 1'b1;

    always #20 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    // Device model: clocks the frame in, samples data on rising edges, optionally acks.
    task automatic run_device();
        logic [10:0] fr;
        bit          ab;
        int          m, h;
        m  = dev_mode;
        h  = dev_half;
        ab = 0;
        fr = '0;
        if (m == 2) return;
        repeat (4) @(negedge clk);
        fr[0] = PS2D;
        for (int i = 1; i <= 11 && !ab; i++) begin
            if (i == 11 && m == 0) begin
                dev_dl = 1'b1;
                repeat (3) @(negedge clk);
            end
            dev_cl = 1'b1;
            for (int k = 0; k < h; k++) begin
                @(negedge clk);
                if (!rst) ab = 1;
            end
            dev_cl = 1'b0;
            if (i <= 10) begin
                fr[i] = PS2D;
                dev_nrise++;
            end
            if (i < 11) begin
                for (int k = 0; k < h; k++) begin
                    @(negedge clk);
                    if (!rst) ab = 1;
                end
            end
        end
        if (ab) begin
            dev_cl = 1'b0;
            dev_dl = 1'b0;
            return;
        end
        repeat (2) @(negedge clk);
        dev_dl = 1'b0;
        rx_q.push_back(fr);
    endtask

    initial begin : device
        forever begin
            @(negedge clk);
            if (rst && PS2C && !PS2D && !dev_dl) begin
                run_device();
                for (int k = 0; k < 2 * TO && rst && PS2C && !PS2D; k++) @(negedge clk);
            end
        end
    end

    // Monitor: line timing and completion scoreboard.
    initial begin : monitor
        logic        prev_cl, prev_dl;
        int          t_cl_rise, t_dl_rise, t_cl_fall;
        exp_t        e;
        logic [10:0] fr;
        prev_cl = 1'b0;
        prev_dl = 1'b0;
        t_cl_rise = 0;
        t_dl_rise = 0;
        t_cl_fall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ps2c_low && !prev_cl) t_cl_rise = cyc;
                if (ps2d_low && !prev_dl && ps2c_low) begin
                    t_dl_rise = cyc;
                    check("inhibit_len", 32'(cyc - t_cl_rise), 32'(INH));
                end
                if (!ps2c_low && prev_cl && ps2d_low) begin
                    t_cl_fall = cyc;
                    check("req_len", 32'(cyc - t_dl_rise), 32'(RQ));
                end
                if (hif.done) begin
                    done_seen++;
                    check("busy_at_done", 32'(hif.busy), 32'(0));
                    check("lines_released", 32'({ps2c_low, ps2d_low}), 32'(0));
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'(exp_q.size()), 32'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check("err", 32'(hif.err), 32'(e.err));
                        if (e.timeout) check("timeout_len", 32'(cyc - t_cl_fall), 32'(TO));
                        if (e.chk_frame) begin
                            if (rx_q.size() == 0) begin
                                check("frame_present", 32'(rx_q.size()), 32'(1));
                            end else begin
                                fr = rx_q.pop_front();
                                check("frame", 32'(fr), 32'(e.frame));
                            end
                        end
                    end
                end
            end
            prev_cl = ps2c_low;
            prev_dl = ps2d_low;
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 4000 && hif.busy; k++) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int mode, input int half, input bit inject);
        exp_t e;
        int   base;
        wait_idle();
        e.frame     = {1'b1, ~^b, b, 1'b0};
        e.chk_frame = (mode != 2);
        e.timeout   = (mode == 2);
        e.err       = (mode != 0);
        dev_mode  = mode;
        dev_half  = half;
        dev_nrise = 0;
        @(negedge clk);
        exp_q.push_back(e);
        base = done_seen;
        hif.din   = b;
        hif.start = 1'b1;
        @(posedge clk);
        #1;
        check("accept_busy", 32'(hif.busy), 32'(1));
        check("accept_clk_low", 32'(ps2c_low), 32'(1));
        hif.start = 1'b0;
        hif.din   = 8'($urandom);
        if (inject) begin
            for (int k = 0; k < 3000 && dev_nrise < 3; k++) @(negedge clk);
            hif.start = 1'b1;
            hif.din   = 8'h12;
            @(negedge clk);
            hif.start = 1'b0;
        end
        for (int k = 0; k < 4000 && done_seen == base; k++) @(negedge clk);
        if (inject) repeat (80) @(negedge clk);
        check("done_count", 32'(done_seen - base), 32'(1));
    endtask

    initial begin : stim
        int base;
        rst       = 1'b0;
        hif.start = 1'b0;
        hif.din   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ps2c_low", 32'(ps2c_low), 32'(0));
        check("rst_ps2d_low", 32'(ps2d_low), 32'(0));
        check("rst_busy", 32'(hif.busy), 32'(0));
        check("rst_done", 32'(hif.done), 32'(0));
        check("rst_err", 32'(hif.err), 32'(0));
        rst = 1'b1;
        repeat (3) @(negedge clk);

        send(8'hED, 0, 20, 1'b0);
        send(8'h00, 0, 20, 1'b0);
        send(8'hFF, 1, 20, 1'b0);
        send(8'($urandom), 2, 20, 1'b0);

        // Reset in the middle of the data bits.
        wait_idle();
        dev_mode  = 0;
        dev_half  = 15;
        dev_nrise = 0;
        @(negedge clk);
        hif.din   = 8'hA5;
        hif.start = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
        for (int k = 0; k < 3000 && dev_nrise < 4; k++) @(negedge clk);
        base = done_seen;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_ps2c_low", 32'(ps2c_low), 32'(0));
        check("midrst_ps2d_low", 32'(ps2d_low), 32'(0));
        check("midrst_busy", 32'(hif.busy), 32'(0));
        check("midrst_done", 32'(hif.done), 32'(0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_done", 32'(done_seen - base), 32'(0));
        send(8'hF4, 0, 18, 1'b0);

        send(8'hED, 0, 20, 1'b1);

        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(8, 25)), 1'b0);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
